// File: rtl/aes_ctrl_seq.sv
// Sequencing controller for the AES accelerator. It takes key and data jobs from the AHB
// slave and drives the key-expansion and cipher datapath. Multi-block streaming, a watchdog
// on the key/cipher done handshakes, and a software abort are supported.
module aes_ctrl_seq #(
  parameter int unsigned BLK_WORDS = 4,
  parameter int unsigned KEY_WORDS = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned BCNT_W    = 16,
  localparam int unsigned MaxWords = (BLK_WORDS > KEY_WORDS) ? BLK_WORDS : KEY_WORDS,
  localparam int unsigned IdxW     = (MaxWords > 1) ? $clog2(MaxWords) : 1
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              start_i,
  input  logic              data_type_i,
  input  logic              enc_dec_i,
  input  logic              more_blocks_i,
  input  logic              data_valid_i,
  input  logic              out_ready_i,
  input  logic              key_done_i,
  input  logic              aes_done_i,
  input  logic              abort_i,
  output logic              opt_mode_o,
  output logic              load_key_o,
  output logic              aes_start_o,
  output logic              rx_shift_o,
  output logic              tx_shift_o,
  output logic [IdxW-1:0]   word_idx_o,
  output logic              done_chg_key_o,
  output logic              key_valid_o,
  output logic              busy_o,
  output logic              error_o,
  output logic [BCNT_W-1:0] blk_count_o
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StKeyRx,
    StKeyWait,
    StDataRx,
    StAesGo,
    StAesWait,
    StTx,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  logic              opt_q, opt_d;
  logic              kv_q, kv_d;
  logic [BCNT_W-1:0] blk_q, blk_d;
  logic              wdog_exp;

  // State and job-context registers.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wdog_q  <= '0;
      opt_q   <= 1'b0;
      kv_q    <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
      opt_q   <= opt_d;
      kv_q    <= kv_d;
      blk_q   <= blk_d;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wdog_d         = wdog_q;
    opt_d          = opt_q;
    kv_d           = kv_q;
    blk_d          = blk_q;
    load_key_o     = 1'b0;
    aes_start_o    = 1'b0;
    rx_shift_o     = 1'b0;
    tx_shift_o     = 1'b0;
    done_chg_key_o = 1'b0;
    // True in the TIMEOUT-th cycle spent waiting; done in that same cycle still wins.
    wdog_exp       = (wdog_q == WdogW'(TIMEOUT - 1));

    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          opt_d  = enc_dec_i;
          idx_d  = '0;
          wdog_d = '0;
          if (data_type_i) begin
            state_d = StKeyRx;
          end else if (kv_q) begin
            state_d = StDataRx;
            blk_d   = '0;
          end else begin
            state_d = StError;
          end
        end
      end
      StKeyRx: begin
        rx_shift_o = data_valid_i;
        if (data_valid_i) begin
          if (idx_q == IdxW'(KEY_WORDS - 1)) begin
            idx_d   = '0;
            wdog_d  = '0;
            state_d = StKeyWait;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StKeyWait: begin
        load_key_o = 1'b1;
        if (key_done_i) begin
          done_chg_key_o = 1'b1;
          kv_d           = 1'b1;
          state_d        = StIdle;
        end else if (wdog_exp) begin
          state_d = StError;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StDataRx: begin
        rx_shift_o = data_valid_i;
        if (data_valid_i) begin
          if (idx_q == IdxW'(BLK_WORDS - 1)) begin
            idx_d   = '0;
            state_d = StAesGo;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StAesGo: begin
        aes_start_o = 1'b1;
        wdog_d      = '0;
        state_d     = StAesWait;
      end
      StAesWait: begin
        if (aes_done_i) begin
          idx_d   = '0;
          state_d = StTx;
        end else if (wdog_exp) begin
          state_d = StError;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StTx: begin
        tx_shift_o = out_ready_i;
        if (out_ready_i) begin
          if (idx_q == IdxW'(BLK_WORDS - 1)) begin
            blk_d   = blk_q + 1'b1;
            idx_d   = '0;
            state_d = more_blocks_i ? StDataRx : StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StError: begin
        // Leaving ERROR only happens through the abort override below.
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides every transition; key and block history survive it.
    if (abort_i && (state_q != StIdle)) begin
      state_d        = StIdle;
      idx_d          = '0;
      wdog_d         = '0;
      opt_d          = opt_q;
      kv_d           = kv_q;
      blk_d          = blk_q;
      done_chg_key_o = 1'b0;
    end
  end

  assign opt_mode_o  = opt_q;
  assign word_idx_o  = idx_q;
  assign key_valid_o = kv_q;
  assign blk_count_o = blk_q;
  assign busy_o      = (state_q != StIdle);
  assign error_o     = (state_q == StError);

endmodule

// File: tb/tb_aes_ctrl_seq.sv
// Scoreboard bench for aes_ctrl_seq: a 4/4-word instance for the main scenarios and an
// 8/8-word instance for the width sweep, both driven from the same inputs.
module tb_aes_ctrl_seq;

  logic clk = 1'b0;
  logic n_rst, start, data_type, enc_dec, more_blocks, data_valid, out_ready;
  logic key_done, aes_done, abort;

  logic        a_opt, a_load_key, a_aes_start, a_rx, a_tx, a_done, a_kv, a_busy, a_err;
  logic [1:0]  a_idx;
  logic [15:0] a_blk;
  logic        b_opt, b_load_key, b_aes_start, b_rx, b_tx, b_done, b_kv, b_busy, b_err;
  logic [2:0]  b_idx;
  logic [15:0] b_blk;

  typedef struct {
    int kind;  // 0 rx_shift, 1 tx_shift, 2 aes_start, 3 done_chg_key
    int idx;
    int blk;
    int opt;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  checks = 0;
  int  failures = 0;
  bit  mon_a = 1'b1;
  bit  mon_b = 1'b0;
  int  max_idx_b = 0;

  always #5 clk = ~clk;

  aes_ctrl_seq #(.BLK_WORDS(4), .KEY_WORDS(4), .TIMEOUT(64), .BCNT_W(16)) dut (
    .clk_i(clk), .n_rst_i(n_rst), .start_i(start), .data_type_i(data_type),
    .enc_dec_i(enc_dec), .more_blocks_i(more_blocks), .data_valid_i(data_valid),
    .out_ready_i(out_ready), .key_done_i(key_done), .aes_done_i(aes_done), .abort_i(abort),
    .opt_mode_o(a_opt), .load_key_o(a_load_key), .aes_start_o(a_aes_start),
    .rx_shift_o(a_rx), .tx_shift_o(a_tx), .word_idx_o(a_idx), .done_chg_key_o(a_done),
    .key_valid_o(a_kv), .busy_o(a_busy), .error_o(a_err), .blk_count_o(a_blk)
  );

  aes_ctrl_seq #(.BLK_WORDS(8), .KEY_WORDS(8), .TIMEOUT(64), .BCNT_W(16)) dut8 (
    .clk_i(clk), .n_rst_i(n_rst), .start_i(start), .data_type_i(data_type),
    .enc_dec_i(enc_dec), .more_blocks_i(more_blocks), .data_valid_i(data_valid),
    .out_ready_i(out_ready), .key_done_i(key_done), .aes_done_i(aes_done), .abort_i(abort),
    .opt_mode_o(b_opt), .load_key_o(b_load_key), .aes_start_o(b_aes_start),
    .rx_shift_o(b_rx), .tx_shift_o(b_tx), .word_idx_o(b_idx), .done_chg_key_o(b_done),
    .key_valid_o(b_kv), .busy_o(b_busy), .error_o(b_err), .blk_count_o(b_blk)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int idx, input int blk, input int opt);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.blk  = blk;
    e.opt  = opt;
    if (mon_a) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 4-word instance: every strobe must match the head of its queue.
  always @(negedge clk) begin
    int  k;
    ev_t e;
    k = -1;
    if (n_rst && mon_a) begin
      if (a_rx) k = 0;
      else if (a_tx) k = 1;
      else if (a_aes_start) k = 2;
      else if (a_done) k = 3;
      if (k >= 0) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_event", k, -1);
        end else begin
          e = qa.pop_front();
          chk("a_event_kind", k, e.kind);
          chk("a_word_idx", int'(a_idx), e.idx);
          chk("a_blk_count", int'(a_blk), e.blk);
          chk("a_opt_mode", int'(a_opt), e.opt);
        end
      end
    end
  end

  // Monitor for the 8-word instance.
  always @(negedge clk) begin
    int  k;
    ev_t e;
    k = -1;
    if (n_rst && mon_b) begin
      if (b_rx) k = 0;
      else if (b_tx) k = 1;
      else if (b_aes_start) k = 2;
      else if (b_done) k = 3;
      if (k >= 0) begin
        if (int'(b_idx) > max_idx_b) max_idx_b = int'(b_idx);
        if (qb.size() == 0) begin
          chk("b_unexpected_event", k, -1);
        end else begin
          e = qb.pop_front();
          chk("b_event_kind", k, e.kind);
          chk("b_word_idx", int'(b_idx), e.idx);
          chk("b_blk_count", int'(b_blk), e.blk);
          chk("b_opt_mode", int'(b_opt), e.opt);
        end
      end
    end
  end

  task automatic rx_words(input int n, input int blk, input int opt, input bit gaps);
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      push(0, i, blk, opt);
      tick();
      data_valid = 1'b0;
      if (gaps) tick();
    end
  endtask

  // One data block from DATA_RX through TX; stray strobes are driven while waiting.
  task automatic do_block(input int blk, input int opt, input bit more, input int n);
    rx_words(n, blk, opt, 1'b0);
    push(2, 0, blk, opt);
    tick();
    out_ready  = 1'b1;
    data_valid = 1'b1;
    tick();
    tick();
    out_ready  = 1'b0;
    data_valid = 1'b0;
    aes_done   = 1'b1;
    tick();
    aes_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      out_ready   = 1'b1;
      more_blocks = more;
      push(1, i, blk, opt);
      tick();
      out_ready   = 1'b0;
      more_blocks = 1'b0;
    end
  endtask

  task automatic start_job(input bit dt, input bit ed);
    start     = 1'b1;
    data_type = dt;
    enc_dec   = ed;
    tick();
    start     = 1'b0;
    data_type = 1'b0;
    enc_dec   = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; data_type = 1'b0; enc_dec = 1'b0; more_blocks = 1'b0;
    data_valid = 1'b0; out_ready = 1'b0; key_done = 1'b0; aes_done = 1'b0; abort = 1'b0;
    #12;
    chk("rst_opt_mode", a_opt, 0);
    chk("rst_load_key", a_load_key, 0);
    chk("rst_aes_start", a_aes_start, 0);
    chk("rst_rx_shift", a_rx, 0);
    chk("rst_tx_shift", a_tx, 0);
    chk("rst_word_idx", a_idx, 0);
    chk("rst_done_chg_key", a_done, 0);
    chk("rst_key_valid", a_kv, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_error", a_err, 0);
    chk("rst_blk_count", a_blk, 0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Data job with no key loaded goes straight to ERROR.
    start_job(1'b0, 1'b0);
    chk("nokey_error", a_err, 1);
    chk("nokey_busy", a_busy, 1);
    tick();
    tick();
    chk("nokey_error_held", a_err, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("nokey_abort_busy", a_busy, 0);
    chk("nokey_abort_error", a_err, 0);

    // Key load with gaps between words; key_done three cycles after the last word.
    start_job(1'b1, 1'b0);
    rx_words(4, 0, 0, 1'b1);
    chk("key_wait_load_key", a_load_key, 1);
    chk("key_wait_key_valid", a_kv, 0);
    tick();
    tick();
    chk("key_wait_load_key_held", a_load_key, 1);
    key_done = 1'b1;
    push(3, 0, 0, 0);
    tick();
    key_done = 1'b0;
    chk("key_loaded_valid", a_kv, 1);
    chk("key_loaded_load_key", a_load_key, 0);
    chk("key_loaded_busy", a_busy, 0);

    // Two-block decrypt stream; enc_dec drops right after start.
    start_job(1'b0, 1'b1);
    do_block(0, 1, 1'b1, 4);
    chk("stream_mid_busy", a_busy, 1);
    do_block(1, 1, 1'b0, 4);
    chk("stream_blk_count", a_blk, 2);
    chk("stream_busy", a_busy, 0);
    chk("stream_opt_mode", a_opt, 1);

    // Watchdog: aes_done withheld for the full TIMEOUT.
    start_job(1'b0, 1'b0);
    rx_words(4, 0, 0, 1'b0);
    push(2, 0, 0, 0);
    tick();
    repeat (63) tick();
    chk("wdog_cycle64_error", a_err, 0);
    chk("wdog_cycle64_busy", a_busy, 1);
    tick();
    chk("wdog_timeout_error", a_err, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wdog_abort_busy", a_busy, 0);

    // Watchdog: aes_done on the last allowed cycle wins.
    start_job(1'b0, 1'b0);
    rx_words(4, 0, 0, 1'b0);
    push(2, 0, 0, 0);
    tick();
    repeat (63) tick();
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    chk("wdog_edge_error", a_err, 0);
    chk("wdog_edge_busy", a_busy, 1);
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      push(1, i, 0, 0);
      tick();
      out_ready = 1'b0;
    end
    chk("wdog_edge_blk_count", a_blk, 1);
    chk("wdog_edge_idle", a_busy, 0);

    // Abort after two words of a data block.
    start_job(1'b0, 1'b0);
    rx_words(2, 0, 0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", a_busy, 0);
    chk("abort_word_idx", a_idx, 0);
    chk("abort_key_valid", a_kv, 1);
    chk("abort_blk_count", a_blk, 0);
    start_job(1'b0, 1'b0);
    do_block(0, 0, 1'b0, 4);
    chk("post_abort_blk_count", a_blk, 1);
    tick();
    chk("a_queue_empty", qa.size(), 0);
    mon_a = 1'b0;

    // Width sweep on the 8-word instance.
    n_rst = 1'b0;
    #2;
    chk("b_rst_busy", b_busy, 0);
    chk("b_rst_word_idx", b_idx, 0);
    @(negedge clk);
    n_rst = 1'b1;
    mon_b = 1'b1;
    tick();
    start_job(1'b1, 1'b0);
    rx_words(8, 0, 0, 1'b0);
    chk("b_key_wait_load_key", b_load_key, 1);
    repeat (64) tick();
    chk("b_key_timeout_error", b_err, 1);
    chk("b_key_timeout_key_valid", b_kv, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start_job(1'b1, 1'b0);
    rx_words(8, 0, 0, 1'b1);
    key_done = 1'b1;
    push(3, 0, 0, 0);
    tick();
    key_done = 1'b0;
    chk("b_key_valid", b_kv, 1);
    start_job(1'b0, 1'b0);
    do_block(0, 0, 1'b0, 8);
    chk("b_blk_count", b_blk, 1);
    chk("b_busy_end", b_busy, 0);
    tick();
    chk("b_max_word_idx", max_idx_b, 7);
    chk("b_queue_empty", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
